// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// FIFO_UART_TX_PARITY_EN adds the PARITY state to the frame FSM.
package fifo_uart_pkg;

    localparam int DATA_W = 8;

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and raises tick
// on the last cycle of each bit period; clear restarts the period.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from a show-ahead FIFO and sends 8N1 frames
// back to back. Define FIFO_UART_TX_PARITY_EN to insert a parity bit after DATA.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic              rd_clk,
    input  logic              rd_rstn,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_empty,
    output logic              rd_en,
    output logic              tx,
    output logic              busy
);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [2:0]        bit_q, bit_d;
    logic              tx_q, tx_d;
    logic              tick;
    logic              pop;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (rd_clk),
        .rst_n (rd_rstn),
        .clear (pop),
        .enable(state_q != ST_IDLE),
        .tick  (tick)
    );

    // The pop is gated by rd_rstn so no byte is taken while reset is held.
    assign pop   = rd_rstn && !rd_empty &&
                   ((state_q == ST_IDLE) || ((state_q == ST_STOP) && tick));
    assign rd_en = pop;
    assign tx    = tx_q;
    assign busy  = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d = ST_START;
                    shift_d = rd_data;
`ifdef FIFO_UART_TX_PARITY_EN
                    par_d   = (^rd_data) ^ PARITY_ODD;
`endif
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (pop) begin
                    state_d = ST_START;
                    shift_d = rd_data;
`ifdef FIFO_UART_TX_PARITY_EN
                    par_d   = (^rd_data) ^ PARITY_ODD;
`endif
                end else if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // tx is registered from the next-state view so it lines up with state_q.
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_q;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule
